rtc_save_restore: RTL and testbench



---
 rtl/rtc_save_restore.sv | 197 +++++++++++++++++++
 tb/tb_rtc_save_restore.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_save_restore.sv
// RTC save/restore: captures the five RTC words written past cartridge SRAM by the
// save loader, then replays them into the cartridge RTC port once loading settles.
module rtc_save_restore #(
    parameter int SETTLE_CYCLES   = 16,
    parameter int WR_GAP          = 4,
    parameter int VALID_TIMEOUT   = 1024,
    parameter int CAPTURE_TIMEOUT = 1048576
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        external_reset_s,
    input  logic        cart_download,
    input  logic        RTC_valid,
    input  logic [16:0] addr_in,
    input  logic [15:0] data_in,
    input  logic        wr_in,
    output logic [16:0] addr_out,
    output logic [15:0] data_out,
    output logic        wr_out,
    output logic        loading_done
);

    localparam int MAX_A   = (SETTLE_CYCLES > WR_GAP) ? SETTLE_CYCLES : WR_GAP;
    localparam int MAX_B   = (VALID_TIMEOUT > CAPTURE_TIMEOUT) ? VALID_TIMEOUT : CAPTURE_TIMEOUT;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(WR_GAP - 1);
    localparam logic [CNT_W-1:0] VALID_LAST   = CNT_W'(VALID_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAPTURE_LAST = CNT_W'(CAPTURE_TIMEOUT - 1);
    localparam logic [2:0]       LAST_IDX     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SETTLE,
        S_REPLAY,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [2:0]        idx;
    logic [2:0]        fire_idx;
    logic              fire;
    logic              cart_q;
    logic              cart_fall;
    logic [4:0]        mask;
    logic              mask_full;
    logic [15:0]       rtc_buf [5];
    logic [7:0]        wr_idx;
    logic              cap_en;
    logic              wr_n;
    logic              ld_n;
    logic              unused_addr_hi;

    // Save sizes are powers of two of at least 512 B, so only the low byte locates the word.
    assign wr_idx         = addr_in[7:0];
    assign unused_addr_hi = ^addr_in[16:8];
    assign cart_fall      = cart_q && !cart_download;
    assign mask_full      = &mask;
    assign cap_en         = wr_in && !cart_download && (wr_idx < 8'd5)
                            && (state == S_IDLE || state == S_WAIT);

    // State register, shared counter, replay index and download edge detector.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            idx    <= '0;
            cart_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            cart_q <= cart_download;
            if (fire) begin
                idx <= fire_idx;
            end
        end
    end

    // Next-state logic; a replay write is issued on the same edge that leaves SETTLE.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        fire     = 1'b0;
        fire_idx = idx;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (cart_fall) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mask_full) begin
                    state_n = S_SETTLE;
                    cnt_n   = '0;
                end else if (cnt == CAPTURE_LAST) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_n  = S_REPLAY;
                    cnt_n    = '0;
                    fire     = 1'b1;
                    fire_idx = 3'd0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_REPLAY: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    if (idx == LAST_IDX) begin
                        state_n = S_VERIFY;
                    end else begin
                        fire     = 1'b1;
                        fire_idx = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_VERIFY: begin
                if (RTC_valid || cnt == VALID_LAST) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                cnt_n = '0;
                // A core reset wipes the cart RTC, so a complete buffer is replayed again.
                if (external_reset_s && mask_full) begin
                    state_n = S_SETTLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
        if (cart_download) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            fire    = 1'b0;
        end
    end

    // Output next-values; both outputs are registered below.
    always_comb begin
        wr_n = fire;
        ld_n = (state == S_DONE) && !cart_download && !(external_reset_s && mask_full);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_out       <= 1'b0;
            loading_done <= 1'b0;
            addr_out     <= '0;
            data_out     <= '0;
        end else begin
            wr_out       <= wr_n;
            loading_done <= ld_n;
            if (fire) begin
                addr_out <= {14'd0, fire_idx};
                data_out <= rtc_buf[fire_idx];
            end
        end
    end

    // Capture buffer and completion mask; a new download discards any partial capture.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mask <= '0;
            for (int i = 0; i < 5; i++) begin
                rtc_buf[i] <= '0;
            end
        end else if (cart_download) begin
            mask <= '0;
        end else if (cap_en) begin
            rtc_buf[wr_idx[2:0]] <= data_in;
            mask[wr_idx[2:0]]    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rtc_save_restore.sv
// Directed bench for rtc_save_restore: capture, replay timing, timeouts, abort,
// soft-reset replay and asynchronous reset.
module tb_rtc_save_restore;

    localparam int S  = 16;
    localparam int G  = 4;
    localparam int V  = 32;
    localparam int CT = 64;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b0;
    logic        external_reset_s = 1'b0;
    logic        cart_download = 1'b0;
    logic        RTC_valid = 1'b0;
    logic [16:0] addr_in = '0;
    logic [15:0] data_in = '0;
    logic        wr_in = 1'b0;
    logic [16:0] addr_out;
    logic [15:0] data_out;
    logic        wr_out;
    logic        loading_done;

    int checks = 0;
    int failures = 0;
    int wr_seen;

    rtc_save_restore #(
        .SETTLE_CYCLES  (S),
        .WR_GAP         (G),
        .VALID_TIMEOUT  (V),
        .CAPTURE_TIMEOUT(CT)
    ) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .external_reset_s(external_reset_s),
        .cart_download   (cart_download),
        .RTC_valid       (RTC_valid),
        .addr_in         (addr_in),
        .data_in         (data_in),
        .wr_in           (wr_in),
        .addr_out        (addr_out),
        .data_out        (data_out),
        .wr_out          (wr_out),
        .loading_done    (loading_done)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dl_pulse;
        cart_download = 1'b1;
        tick();
        cart_download = 1'b0;
    endtask

    task automatic wr_word(input logic [16:0] a, input logic [15:0] d);
        addr_in = a;
        data_in = d;
        wr_in   = 1'b1;
        tick();
        wr_in   = 1'b0;
    endtask

    task automatic write_all(input logic [79:0] w);
        for (int i = 0; i < 5; i++) begin
            wr_word(17'(i), w[i*16 +: 16]);
        end
    endtask

    task automatic wait_wr(input string tag);
        int n;
        n = 0;
        while (wr_out !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_wait_wr"}, 32'(wr_out), 32'd1);
    endtask

    // Entered with the first pulse visible; leaves G-1 cycles after the last pulse.
    task automatic check_replay(input string tag, input logic [79:0] w);
        for (int i = 0; i < 5; i++) begin
            chk({tag, "_wr"}, 32'(wr_out), 32'd1);
            chk({tag, "_addr"}, 32'(addr_out), 32'(i));
            chk({tag, "_data"}, 32'(data_out), 32'(w[i*16 +: 16]));
            tick();
            chk({tag, "_gap_wr"}, 32'(wr_out), 32'd0);
            chk({tag, "_hold_data"}, 32'(data_out), 32'(w[i*16 +: 16]));
            for (int g = 2; g < G; g++) begin
                tick();
            end
            if (i < 4) begin
                tick();
            end
        end
    endtask

    task automatic finish_valid(input string tag);
        RTC_valid = 1'b1;
        tick();
        tick();
        chk({tag, "_ld_early"}, 32'(loading_done), 32'd0);
        tick();
        chk({tag, "_ld"}, 32'(loading_done), 32'd1);
        RTC_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_wr", 32'(wr_out), 32'd0);
        chk("rst_ld", 32'(loading_done), 32'd0);
        chk("rst_addr", 32'(addr_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Basic capture and replay with exact first-write latency
        dl_pulse();
        write_all({16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111});
        for (int i = 0; i < S; i++) begin
            tick();
        end
        chk("t1_latency_early", 32'(wr_out), 32'd0);
        tick();
        check_replay("t1", {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111});
        finish_valid("t1");

        // Overwrite, out-of-range and high-address writes
        dl_pulse();
        chk("t2_ld_cleared", 32'(loading_done), 32'd0);
        wr_word(17'd2, 16'hAAAA);
        wr_word(17'd5, 16'hDEAD);
        wr_word(17'd200, 16'hBEEF);
        wr_word(17'd0, 16'h1234);
        wr_word(17'd1, 16'h5678);
        wr_word(17'd2, 16'hBBBB);
        wr_word(17'h10003, 16'h9ABC);
        wr_word(17'd4, 16'hDEF0);
        wait_wr("t2");
        check_replay("t2", {16'hDEF0, 16'h9ABC, 16'hBBBB, 16'h5678, 16'h1234});
        finish_valid("t2");

        // Capture timeout with no writes
        dl_pulse();
        wr_seen = 0;
        for (int n = 1; n <= CT + 2; n++) begin
            tick();
            if (wr_out === 1'b1) wr_seen++;
            if (n == CT + 1) chk("t3_ld_early", 32'(loading_done), 32'd0);
            if (n == CT + 2) chk("t3_ld_timeout", 32'(loading_done), 32'd1);
        end
        chk("t3_no_wr", 32'(wr_seen), 32'd0);

        // Abort mid-replay, then a fresh capture
        dl_pulse();
        write_all({16'h0E0E, 16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A});
        wait_wr("t4");
        chk("t4_p0_addr", 32'(addr_out), 32'd0);
        for (int i = 0; i < G; i++) tick();
        chk("t4_p1_wr", 32'(wr_out), 32'd1);
        chk("t4_p1_data", 32'(data_out), 32'h0B0B);
        cart_download = 1'b1;
        tick();
        chk("t4_abort_wr", 32'(wr_out), 32'd0);
        chk("t4_abort_ld", 32'(loading_done), 32'd0);
        wr_seen = 0;
        for (int i = 0; i < 3 * G; i++) begin
            tick();
            if (wr_out === 1'b1) wr_seen++;
        end
        chk("t4_abort_quiet", 32'(wr_seen), 32'd0);
        cart_download = 1'b0;
        write_all({16'h7005, 16'h7004, 16'h7003, 16'h7002, 16'h7001});
        wait_wr("t4b");
        check_replay("t4b", {16'h7005, 16'h7004, 16'h7003, 16'h7002, 16'h7001});
        finish_valid("t4b");

        // RTC_valid never arrives; soft reset replays the same words
        dl_pulse();
        write_all({16'hC0DE, 16'hB00C, 16'hA11A, 16'h9001, 16'h8000});
        wait_wr("t5");
        check_replay("t5", {16'hC0DE, 16'hB00C, 16'hA11A, 16'h9001, 16'h8000});
        for (int i = 0; i < V + 1; i++) tick();
        chk("t5_ld_early", 32'(loading_done), 32'd0);
        tick();
        chk("t5_ld_timeout", 32'(loading_done), 32'd1);
        external_reset_s = 1'b1;
        tick();
        external_reset_s = 1'b0;
        chk("t5_ld_drop", 32'(loading_done), 32'd0);
        for (int i = 0; i < S - 1; i++) tick();
        chk("t5_resettle_early", 32'(wr_out), 32'd0);
        tick();
        check_replay("t5r", {16'hC0DE, 16'hB00C, 16'hA11A, 16'h9001, 16'h8000});
        finish_valid("t5r");

        // Asynchronous reset mid-replay
        dl_pulse();
        write_all({16'h0505, 16'h0404, 16'h0303, 16'h0202, 16'h0101});
        wait_wr("t6");
        for (int i = 0; i < 2 * G; i++) tick();
        chk("t6_p2_addr", 32'(addr_out), 32'd2);
        reset = 1'b1;
        #2;
        chk("t6_async_wr", 32'(wr_out), 32'd0);
        chk("t6_async_addr", 32'(addr_out), 32'd0);
        chk("t6_async_data", 32'(data_out), 32'd0);
        chk("t6_async_ld", 32'(loading_done), 32'd0);
        tick();
        reset = 1'b0;
        wr_seen = 0;
        for (int i = 0; i < S + 5 * G + 4; i++) begin
            tick();
            if (wr_out === 1'b1) wr_seen++;
        end
        chk("t6_post_reset_quiet", 32'(wr_seen), 32'd0);
        chk("t6_post_reset_ld", 32'(loading_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
